i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (slave) endpoint, the responder counterpart to the team's I2C master. It oversamples the external SCL/SDA lines on the system clock and detects START, repeated START and STOP conditions. It matches a fixed 7-bit address, acknowledges it, then streams received bytes to local logic or fetches bytes from local logic to transmit. SDA is driven open-drain: the block only ever pulls SDA low or releases it.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit address this target responds to.
- clk  in  1  system clock; must be ≥ 16× SCL frequency.
- reset  in  1  asynchronous, active-high; clock clk.
- scl_in  in  1  SCL pin, asynchronous.
- sda_in  in  1  SDA pin, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release. The pad ties the output value to 0.
- rx_data  out  8  last byte written by the master; held until the next byte.
- rx_valid  out  1  1-cycle pulse when rx_data updates.
- tx_data  in  8  byte to return on a read; sampled as defined below.
- tx_req  out  1  1-cycle pulse requesting the next tx_data.
- busy  out  1  1 while state ≠ IDLE.

## Operation
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer plus one history FF.
  - Synchronizer and history FFs reset to 1.
  - Events are defined on the synchronized signals:
    - scl_rise, scl_fall: edges of SCL.
    - start: SDA 1→0 while SCL = 1.
    - stop: SDA 0→1 while SCL = 1.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- bit_cnt is 3 bits, counts 0..7, and is cleared on entry to each byte state.
- SDA sampling and drive rules:
  - SDA is sampled only on scl_rise.
  - sda_oe changes only on scl_fall, start or stop.
- Global rules (override all states):
  - start → ADDR, bit_cnt = 0, sda_oe = 0. This covers repeated START from any state.
  - stop → IDLE, sda_oe = 0.
- ADDR:
  - Shift SDA MSB-first on each scl_rise; the 8th bit is R/W.
  - On the scl_fall after the 8th bit:
    - Address equals SLAVE_ADDR → ADDR_ACK, sda_oe = 1.
    - Otherwise → WAIT_STOP, sda_oe = 0.
- ADDR_ACK:
  - R/W = 1: tx_req pulses on scl_rise of the ACK bit.
  - On the next scl_fall:
    - R/W = 0 → WRITE, sda_oe = 0.
    - R/W = 1 → READ. tx_data is latched into the shift register in that cycle; sda_oe = ~tx_data[7].
- WRITE:
  - Shift SDA on each scl_rise.
  - On the 8th scl_rise: rx_data updates and rx_valid pulses in the same cycle.
  - On the following scl_fall: → WRITE_ACK, sda_oe = 1. Every write byte is always ACKed.
- WRITE_ACK: on the next scl_fall → WRITE, sda_oe = 0.
- READ:
  - On each scl_fall, drive sda_oe = ~next shift bit, MSB-first.
  - On the scl_fall after the 8th bit: sda_oe = 0 → READ_ACK.
- READ_ACK: sample the master's ACK on scl_rise.
  - SDA = 0 (ACK): tx_req pulses in the same cycle. On the next scl_fall, latch tx_data, drive its bit 7 → READ.
  - SDA = 1 (NACK) → WAIT_STOP, sda_oe = 0.
- WAIT_STOP: ignore SCL and keep sda_oe = 0 until start or stop.
- Simultaneity: a start/stop event and an SCL edge cannot occur in the same cycle per protocol. If both are flagged, start/stop wins.

## Timing
- Reset values: sda_oe = 0, rx_data = 8'h00, rx_valid = 0, tx_req = 0, busy = 0, state = IDLE.
- Pin-to-event latency: 3 clk cycles (2 sync + 1 edge detect).
- sda_oe updates on the clk edge after the event is detected: ≤ 4 clk after the pin edge. This is within SCL-low hold budget at ≥ 16× oversampling.
- tx_data must be stable from the tx_req pulse to the next scl_fall detection, ≥ half an SCL period.
- rx_valid and tx_req are each exactly 1 cycle wide. Each pulses at most once per byte.
- busy rises the cycle after start is detected. It falls the cycle after stop is detected or after reset.
- Reset asserted mid-transfer: all outputs return to reset values immediately and sda_oe = 0, releasing the bus. After release, the block remains in IDLE until a new START.

## Test plan
- Write: START, 0xA0 (addr 0x50, W), 0xA5, 0x3C, STOP.
  - sda_oe = 1 during all three ACK bits.
  - rx_valid pulses twice, with rx_data 0xA5 then 0x3C.
  - busy = 0 after STOP.
- Wrong address: START, 0xA2 (addr 0x51), 0x55, STOP.
  - sda_oe stays 0 throughout, so the master sees NACK.
  - No rx_valid pulses; busy = 0 after STOP.
- Read: START, 0xA1, tx_data = 0xC3 then 0x5A, master ACKs byte 1 and NACKs byte 2, STOP.
  - The SDA line carries 0xC3 then 0x5A.
  - tx_req pulses exactly twice; sda_oe = 0 after the NACK.
- Repeated START: write 0xA0, 0x10, then Sr, 0xA1, read 1 byte (tx_data 0x77), NACK, STOP.
  - rx_data = 0x10 and read data = 0x77.
  - State passes WRITE → ADDR without passing through IDLE.
- Reset mid-read: assert reset while driving bit 3 of 0x00 (sda_oe = 1).
  - sda_oe = 0 on the same cycle and all outputs return to reset values.
  - A subsequent full write of 0xA0, 0x99 succeeds with rx_data = 0x99.
- STOP mid-byte: START, 0xA0, 4 bits of data, STOP.
  - Block goes to IDLE with no rx_valid pulse and sda_oe = 0.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address match,
// byte receive to local logic and byte transmit from local logic. SDA is open-drain.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StAddr     = 3'd1;
    localparam logic [2:0] StAddrAck  = 3'd2;
    localparam logic [2:0] StWrite    = 3'd3;
    localparam logic [2:0] StWriteAck = 3'd4;
    localparam logic [2:0] StRead     = 3'd5;
    localparam logic [2:0] StReadAck  = 3'd6;
    localparam logic [2:0] StWaitStop = 3'd7;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;  // 8th bit seen (ADDR/WRITE) or ACK seen (READ_ACK)
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;

    // Two-stage synchronizers plus history stage; idle bus level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    // Protocol FSM: START/STOP override everything, otherwise act on SCL edges per state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;

        if (start_det) begin
            state_d     = StAddr;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        rw_d = shift_q[0];
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d  = StAddrAck;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = StWaitStop;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_rise && rw_q) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d   = 3'd0;
                        byte_done_d = 1'b0;
                        if (rw_q) begin
                            state_d  = StRead;
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                        end else begin
                            state_d  = StWrite;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StWrite: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = {shift_q[6:0], sda_s};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d  = StWriteAck;
                        sda_oe_d = 1'b1;
                    end
                end
                StWriteAck: begin
                    if (scl_fall) begin
                        state_d     = StWrite;
                        sda_oe_d    = 1'b0;
                        bit_cnt_d   = 3'd0;
                        byte_done_d = 1'b0;
                    end
                end
                StRead: begin
                    // Bit 7 is already on the line at entry; each fall presents the next bit.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_d     = StReadAck;
                            sda_oe_d    = 1'b0;
                            byte_done_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                        end
                    end
                end
                StReadAck: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_d    = 1'b1;
                            byte_done_d = 1'b1;
                        end else begin
                            state_d  = StWaitStop;
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        state_d     = StRead;
                        shift_d     = tx_data;
                        sda_oe_d    = ~tx_data[7];
                        bit_cnt_d   = 3'd0;
                        byte_done_d = 1'b0;
                    end
                end
                default: begin
                    // Idle and WaitStop: hold SDA released until START/STOP.
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level I2C master model driving open-drain SDA, table of write
// transactions plus hand-written read, repeated-START, reset and STOP corner cases.
`timescale 1ns/1ps
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int idle_cnt = 0;
    int wide_cnt = 0;
    logic rxv_prev = 1'b0;
    logic txr_prev = 1'b0;

    // Open-drain wired-AND of master and target.
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters and width watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (!busy) idle_cnt <= idle_cnt + 1;
        if ((rx_valid && rxv_prev) || (tx_req && txr_prev)) wide_cnt <= wide_cnt + 1;
        rxv_prev <= rx_valid;
        txr_prev <= tx_req;
    end

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] data_b;
        logic       exp_aack;
        logic       exp_dack;
        int         exp_rx;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Quarter SCL period = 8 clk, SCL period = 32 clk.
    task automatic q();
        repeat (8) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic send_bit(input logic b, output logic rb);
        sda_m = b; q();
        scl_m = 1'b1; q();
        rb = sda_line; q();
        scl_m = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic rb;
        for (int i = 7; i >= 0; i--) send_bit(d[i], rb);
        send_bit(1'b1, rb);
        ack = ~rb;
    endtask

    // Reads 8 bits, then answers ACK (m_ack=1) or NACK; next_tx is presented before the ACK bit.
    task automatic read_byte(input logic m_ack, input logic [7:0] next_tx, output logic [7:0] d);
        logic rb;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, rb);
            d = {d[6:0], rb};
        end
        tx_data = next_tx;
        send_bit(~m_ack, rb);
    endtask

    initial begin
        logic       ack;
        logic       rb;
        logic [7:0] d;
        int         rx0, tx0, idle0;

        vecs[0] = '{8'hA0, 8'hA5, 1'b1, 1'b1, 1, 8'hA5};
        vecs[1] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 1, 8'h3C};
        vecs[2] = '{8'hA2, 8'h55, 1'b0, 1'b0, 0, 8'h3C};
        vecs[3] = '{8'hA0, 8'h00, 1'b1, 1'b1, 1, 8'h00};
        vecs[4] = '{8'h20, 8'hFF, 1'b0, 1'b0, 0, 8'h00};
        vecs[5] = '{8'hA0, 8'h81, 1'b1, 1'b1, 1, 8'h81};
        vecs[6] = '{8'hB0, 8'h7E, 1'b0, 1'b0, 0, 8'h81};

        repeat (3) @(posedge clk);
        #1;
        chk("reset sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("reset rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset tx_req", {31'd0, tx_req}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        q();

        // Single-byte write transactions, matching and non-matching addresses.
        for (int i = 0; i < 7; i++) begin
            rx0 = rx_cnt;
            i2c_start();
            chk($sformatf("v%0d busy in txn", i), {31'd0, busy}, 32'd1);
            write_byte(vecs[i].addr_b, ack);
            chk($sformatf("v%0d addr ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_aack});
            write_byte(vecs[i].data_b, ack);
            chk($sformatf("v%0d data ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_dack});
            i2c_stop();
            q();
            chk($sformatf("v%0d rx_valid pulses", i), rx_cnt - rx0, vecs[i].exp_rx);
            chk($sformatf("v%0d rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            chk($sformatf("v%0d busy after stop", i), {31'd0, busy}, 32'd0);
        end

        // Two-byte read: ACK first byte, NACK second.
        tx0 = tx_cnt;
        tx_data = 8'hC3;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("read addr ack", {31'd0, ack}, 32'd1);
        read_byte(1'b1, 8'h5A, d);
        chk("read byte1", {24'd0, d}, 32'hC3);
        read_byte(1'b0, 8'h00, d);
        chk("read byte2", {24'd0, d}, 32'h5A);
        chk("read sda_oe after nack", {31'd0, sda_oe}, 32'd0);
        chk("read tx_req pulses", tx_cnt - tx0, 32'd2);
        i2c_stop();
        q();
        chk("read busy after stop", {31'd0, busy}, 32'd0);

        // Write then repeated START into a one-byte read; busy must never drop.
        tx_data = 8'h77;
        i2c_start();
        idle0 = idle_cnt;
        write_byte(8'hA0, ack);
        write_byte(8'h10, ack);
        chk("rs write ack", {31'd0, ack}, 32'd1);
        i2c_rstart();
        write_byte(8'hA1, ack);
        chk("rs read addr ack", {31'd0, ack}, 32'd1);
        chk("rs no idle between", idle_cnt - idle0, 32'd0);
        read_byte(1'b0, 8'h00, d);
        chk("rs read data", {24'd0, d}, 32'h77);
        chk("rs rx_data", {24'd0, rx_data}, 32'h10);
        i2c_stop();
        q();

        // Reset while the target is driving bit 3 of 0x00.
        tx_data = 8'h00;
        i2c_start();
        write_byte(8'hA1, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1, rb);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        chk("mid-read sda_oe driven", {31'd0, sda_oe}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst pulses", {30'd0, rx_valid, tx_req}, 32'd0);
        q();
        #2 reset = 1'b0;
        q(); q();
        chk("post-rst idle", {31'd0, busy}, 32'd0);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h99, ack);
        chk("post-rst data ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        q();
        chk("post-rst rx_data", {24'd0, rx_data}, 32'h99);

        // STOP after 4 data bits: no byte delivered.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        send_bit(1'b1, rb);
        send_bit(1'b0, rb);
        send_bit(1'b1, rb);
        send_bit(1'b0, rb);
        i2c_stop();
        q();
        chk("partial no rx_valid", rx_cnt - rx0, 32'd0);
        chk("partial busy", {31'd0, busy}, 32'd0);
        chk("partial sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("partial rx_data kept", {24'd0, rx_data}, 32'h99);

        chk("pulse width", wide_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
